// File: rtl/branch_redirect_unit_pkg.sv
// Shared types and constants for the fetch-side branch redirect unit.
// Holds the fetch FSM encoding, the PC increment and the default boot address.
package branch_redirect_unit_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    REDIR = 2'b10
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/branch_redirect_unit_if.sv
// EX-stage branch resolution inputs and IF-stage fetch outputs of the redirect unit.
// The pipeline side uses the master modport; the redirect unit uses slave.
interface branch_redirect_unit_if;

  logic        ex_branch;
  logic        ex_zero;
  logic [31:0] ex_pc;
  logic        stall;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        flush_ifid;
  logic        flush_idex;

  modport master (
    output ex_branch, ex_zero, ex_pc, stall,
    input  if_pc, if_pc4, if_valid, flush_ifid, flush_idex
  );

  modport slave (
    input  ex_branch, ex_zero, ex_pc, stall,
    output if_pc, if_pc4, if_valid, flush_ifid, flush_idex
  );

endinterface

// File: rtl/branch_redirect_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Used for the branch performance statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// IF-stage fetch PC owner: redirects on taken EX branches, flushes the two
// younger pipeline registers, holds on load-use stalls and counts branch events.
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_redirect_unit_if.slave  br,
  output logic [CNT_W-1:0]       perf_branch,
  output logic [CNT_W-1:0]       perf_taken,
  output logic [CNT_W-1:0]       perf_flush
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         taken;
  logic         branch_seen;

  // In REDIR the EX stage holds the squashed bubble, so its branch flag is
  // ignored; rst_n gating keeps the flushes quiet while reset is held.
  assign taken       = rst_n & br.ex_branch & br.ex_zero & (state_q != REDIR);
  assign branch_seen = br.ex_branch & (state_q == RUN);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q + PC_INC;

    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = taken ? REDIR : RUN;
      REDIR:   state_d = RUN;
      default: state_d = BOOT;
    endcase

    // Taken wins over stall: the stalled instruction is being squashed anyway.
    if (taken) begin
      pc_d = br.ex_pc;
    end else if (br.stall || (state_q == BOOT)) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // if_pc4 comes from the registered PC so instruction memory sees a stable pair.
  assign br.if_pc      = pc_q;
  assign br.if_pc4     = pc_q + PC_INC;
  assign br.if_valid   = (state_q != BOOT);
  assign br.flush_ifid = taken;
  assign br.flush_idex = taken;

  sat_counter #(.W(CNT_W)) u_cnt_branch (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (branch_seen),
    .count (perf_branch)
  );

  sat_counter #(.W(CNT_W)) u_cnt_taken (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (taken),
    .count (perf_taken)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (taken),
    .count (perf_flush)
  );

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed self-checking bench for branch_redirect_unit; 4-bit counters make
// saturation reachable in a few dozen cycles.
module tb_branch_redirect_unit;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] perf_branch, perf_taken, perf_flush;

  int tests_run    = 0;
  int tests_failed = 0;

  branch_redirect_unit_if br ();

  branch_redirect_unit #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .br          (br),
    .perf_branch (perf_branch),
    .perf_taken  (perf_taken),
    .perf_flush  (perf_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic b, input logic z, input logic [31:0] p, input logic s);
    br.ex_branch = b;
    br.ex_zero   = z;
    br.ex_pc     = p;
    br.stall     = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 32'h80, 1'b1);
    #1;
    tests_run++; if (br.flush_ifid !== 1'b0) begin tests_failed++; $display("FAIL reset_flush_ifid got %b exp 0", br.flush_ifid); end
    tests_run++; if (br.flush_idex !== 1'b0) begin tests_failed++; $display("FAIL reset_flush_idex got %b exp 0", br.flush_idex); end
    tests_run++; if (br.if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", br.if_valid); end
    tests_run++; if (br.if_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h exp 0", br.if_pc); end
    tests_run++; if ({perf_branch, perf_taken, perf_flush} !== '0) begin tests_failed++; $display("FAIL reset_perf got %h/%h/%h exp 0", perf_branch, perf_taken, perf_flush); end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    tests_run++; if (br.if_pc !== 32'h0 || br.if_valid !== 1'b0) begin tests_failed++; $display("FAIL boot_cycle got pc %h v %b exp 0 v 0", br.if_pc, br.if_valid); end
    tick();
    tests_run++; if (br.if_pc !== 32'h0 || br.if_valid !== 1'b1) begin tests_failed++; $display("FAIL first_run got pc %h v %b exp 0 v 1", br.if_pc, br.if_valid); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests_run++; if (br.if_pc !== 32'(4 * i) || br.if_valid !== 1'b1) begin tests_failed++; $display("FAIL seq_pc%0d got %h v %b exp %h v 1", i, br.if_pc, br.if_valid, 32'(4 * i)); end
    end
    tests_run++; if (br.if_pc4 !== 32'h10) begin tests_failed++; $display("FAIL pc4 got %h exp 10", br.if_pc4); end
    tick();
  endtask

  task automatic test_taken_branch();
    tests_run++; if (br.if_pc !== 32'h10) begin tests_failed++; $display("FAIL taken_start_pc got %h exp 10", br.if_pc); end
    drive(1'b1, 1'b1, 32'h40, 1'b0);
    #1;
    tests_run++; if (br.flush_ifid !== 1'b1 || br.flush_idex !== 1'b1) begin tests_failed++; $display("FAIL taken_flush got %b%b exp 11", br.flush_ifid, br.flush_idex); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    tests_run++; if (br.if_pc !== 32'h40 || br.if_valid !== 1'b1) begin tests_failed++; $display("FAIL taken_target got %h v %b exp 40 v 1", br.if_pc, br.if_valid); end
    tests_run++; if (perf_taken !== 4'd1 || perf_branch !== 4'd1 || perf_flush !== 4'd1) begin tests_failed++; $display("FAIL taken_perf got b%0d t%0d f%0d exp 1/1/1", perf_branch, perf_taken, perf_flush); end
    tests_run++; if (br.flush_ifid !== 1'b0) begin tests_failed++; $display("FAIL redir_noflush got %b exp 0", br.flush_ifid); end
    tick();
    tests_run++; if (br.if_pc !== 32'h44) begin tests_failed++; $display("FAIL after_redir got %h exp 44", br.if_pc); end
  endtask

  task automatic test_not_taken();
    drive(1'b1, 1'b1, 32'h1C, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tests_run++; if (br.if_pc !== 32'h20) begin tests_failed++; $display("FAIL nt_start_pc got %h exp 20", br.if_pc); end
    drive(1'b1, 1'b0, 32'h99, 1'b0);
    #1;
    tests_run++; if (br.flush_ifid !== 1'b0 || br.flush_idex !== 1'b0) begin tests_failed++; $display("FAIL nt_flush got %b%b exp 00", br.flush_ifid, br.flush_idex); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tests_run++; if (br.if_pc !== 32'h24) begin tests_failed++; $display("FAIL nt_next_pc got %h exp 24", br.if_pc); end
    tests_run++; if (perf_branch !== 4'd3 || perf_taken !== 4'd2) begin tests_failed++; $display("FAIL nt_perf got b%0d t%0d exp 3/2", perf_branch, perf_taken); end
  endtask

  task automatic test_stall();
    tick(); tick(); tick();
    tests_run++; if (br.if_pc !== 32'h30) begin tests_failed++; $display("FAIL stall_start_pc got %h exp 30", br.if_pc); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++; if (br.flush_ifid !== 1'b0 || br.flush_idex !== 1'b0) begin tests_failed++; $display("FAIL stall_flush%0d got %b%b exp 00", i, br.flush_ifid, br.flush_idex); end
      tick();
      tests_run++; if (br.if_pc !== 32'h30) begin tests_failed++; $display("FAIL stall_hold%0d got %h exp 30", i, br.if_pc); end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tests_run++; if (br.if_pc !== 32'h34) begin tests_failed++; $display("FAIL stall_resume got %h exp 34", br.if_pc); end
  endtask

  task automatic test_stall_with_taken();
    drive(1'b1, 1'b1, 32'h100, 1'b1);
    #1;
    tests_run++; if (br.flush_ifid !== 1'b1 || br.flush_idex !== 1'b1) begin tests_failed++; $display("FAIL st_taken_flush got %b%b exp 11", br.flush_ifid, br.flush_idex); end
    tick();
    tests_run++; if (br.if_pc !== 32'h100) begin tests_failed++; $display("FAIL st_taken_pc got %h exp 100", br.if_pc); end
    drive(1'b1, 1'b1, 32'h200, 1'b0);
    #1;
    tests_run++; if (br.flush_ifid !== 1'b0 || br.flush_idex !== 1'b0) begin tests_failed++; $display("FAIL redir_ignore_flush got %b%b exp 00", br.flush_ifid, br.flush_idex); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tests_run++; if (br.if_pc !== 32'h104) begin tests_failed++; $display("FAIL redir_ignore_pc got %h exp 104", br.if_pc); end
    tests_run++; if (perf_taken !== 4'd3 || perf_branch !== 4'd4 || perf_flush !== 4'd3) begin tests_failed++; $display("FAIL redir_ignore_perf got b%0d t%0d f%0d exp 4/3/3", perf_branch, perf_taken, perf_flush); end
  endtask

  task automatic test_wrap();
    tick();
    drive(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tests_run++; if (br.if_pc !== 32'hFFFF_FFFC || br.if_pc4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_pre got %h/%h exp fffffffc/0", br.if_pc, br.if_pc4); end
    tick();
    tests_run++; if (br.if_pc !== 32'h0) begin tests_failed++; $display("FAIL wrap got %h exp 0", br.if_pc); end
  endtask

  task automatic test_reset_mid_redirect();
    drive(1'b1, 1'b1, 32'h500, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tests_run++; if (br.if_pc !== 32'h500) begin tests_failed++; $display("FAIL midrst_pre got %h exp 500", br.if_pc); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (br.if_pc !== 32'h0 || br.if_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_async got pc %h v %b exp 0 v 0", br.if_pc, br.if_valid); end
    tests_run++; if ({perf_branch, perf_taken, perf_flush} !== '0) begin tests_failed++; $display("FAIL midrst_perf got %h/%h/%h exp 0", perf_branch, perf_taken, perf_flush); end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++; if (br.if_pc !== 32'h0 || br.if_valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_lost got pc %h v %b exp 0 v 1", br.if_pc, br.if_valid); end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b1, 32'h40, 1'b0);
      #1;
      if (i == 16) begin
        tests_run++; if (br.flush_ifid !== 1'b1) begin tests_failed++; $display("FAIL sat_flush got %b exp 1", br.flush_ifid); end
      end
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      if (i == 15) begin
        tests_run++; if (perf_taken !== 4'd15 || perf_branch !== 4'd15) begin tests_failed++; $display("FAIL sat_reach got b%0d t%0d exp 15/15", perf_branch, perf_taken); end
      end
    end
    tests_run++; if (perf_taken !== 4'd15 || perf_flush !== 4'd15 || perf_branch !== 4'd15) begin tests_failed++; $display("FAIL sat_hold got b%0d t%0d f%0d exp 15/15/15", perf_branch, perf_taken, perf_flush); end
    tests_run++; if (br.if_pc !== 32'h44) begin tests_failed++; $display("FAIL sat_pc got %h exp 44", br.if_pc); end
  endtask

  initial begin
    test_reset();
    test_taken_branch();
    test_not_taken();
    test_stall();
    test_stall_with_taken();
    test_wrap();
    test_reset_mid_redirect();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
